// File: rtl/uart_rx_8e1.sv
// ---------------------------------------------------------------------------
// uart_rx_8e1 : fixed-rate 8E1 UART receiver (1 start, 8 data LSB-first,
//               1 even-parity, 1 stop), 14 clocks per bit from a 3.125 MHz clock.
//
// Ports:
//   clk_3125    in   1  system clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   rx          in   1  serial line, idle high, synchronous to clk_3125
//   rx_msg      out  8  last received byte, or ERR_CHAR on a bad frame
//   rx_parity   out  1  parity bit exactly as received on the line
//   rx_complete out  1  one-clock pulse when rx_msg/rx_parity are loaded
//
// Optional feature: define UART_RX_FRAMING_CHECK_EN to treat a stop bit
// sampled 0 as a framing error (ERR_CHAR reported; the receiver then waits
// for the line to return high before accepting another start bit).
// ---------------------------------------------------------------------------
module uart_rx_8e1 #(
    parameter int         CLKS_PER_BIT = 14,
    parameter int         SAMPLE_POINT = 7,
    parameter logic [7:0] ERR_CHAR     = 8'h3F
) (
    input  logic       clk_3125,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_msg,
    output logic       rx_parity,
    output logic       rx_complete
);

`ifdef UART_RX_FRAMING_CHECK_EN
    localparam logic FRAMING_CHECK = 1'b1;
`else
    localparam logic FRAMING_CHECK = 1'b0;
`endif

    // Counter must reach CLKS_PER_BIT: the stop bit is extended by one edge
    // so results load on the edge that also starts the next frame.
    localparam int             CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]  C_SAMPLE = CW'(SAMPLE_POINT);
    localparam logic [CW-1:0]  C_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  C_END    = CW'(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_next;
    logic [7:0]    r_shift;
    logic          r_par_rx;
    logic          r_stop;
    logic          r_wait_high;
    logic [7:0]    r_msg;
    logic          r_parity;
    logic          r_complete;
    logic          w_sample;
    logic          w_load;
    logic          w_frame_err;
    logic          w_frame_ok;

    function automatic logic f_even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    assign w_sample    = (r_cnt == C_SAMPLE);
    assign w_frame_err = FRAMING_CHECK & ~r_stop;
    assign w_frame_ok  = (r_par_rx == f_even_parity(r_shift)) & ~w_frame_err;

    // State, bit-clock counter and data-bit index registers.
    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
        end
    end

    // Next-state, counter and load-strobe decode.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + CW'(1'b1);
        w_bit_next   = r_bit;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                w_bit_next = 3'd0;
                if (!rx && !r_wait_high) begin
                    // This edge is frame edge 0, so the next edge is index 1.
                    w_state_next = S_START;
                    w_cnt_next   = CW'(1'b1);
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_START: begin
                if (w_sample && rx) begin
                    // Start bit did not last to mid-bit: treat as a glitch.
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == C_LAST) begin
                    w_state_next = S_DATA;
                    w_cnt_next   = '0;
                end else begin
                    w_state_next = S_START;
                end
            end
            S_DATA: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_next = '0;
                    if (r_bit == 3'd7) begin
                        w_state_next = S_PARITY;
                        w_bit_next   = 3'd0;
                    end else begin
                        w_bit_next   = r_bit + 3'd1;
                    end
                end else begin
                    w_state_next = S_DATA;
                end
            end
            S_PARITY: begin
                if (r_cnt == C_LAST) begin
                    w_state_next = S_STOP;
                    w_cnt_next   = '0;
                end else begin
                    w_state_next = S_PARITY;
                end
            end
            S_STOP: begin
                if (r_cnt == C_END) begin
                    // Load edge doubles as edge 0 of a back-to-back frame.
                    w_load = 1'b1;
                    if (!rx && !w_frame_err) begin
                        w_state_next = S_START;
                        w_cnt_next   = CW'(1'b1);
                    end else begin
                        w_state_next = S_IDLE;
                        w_cnt_next   = '0;
                    end
                end else begin
                    w_state_next = S_STOP;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
                w_bit_next   = 3'd0;
            end
        endcase
    end

    // Mid-bit sampling of data, parity and stop bits, plus output loading.
    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= 8'h00;
            r_par_rx    <= 1'b0;
            r_stop      <= 1'b1;
            r_wait_high <= 1'b0;
            r_msg       <= 8'h00;
            r_parity    <= 1'b0;
            r_complete  <= 1'b0;
        end else begin
            r_complete <= w_load;
            if (r_state == S_DATA && w_sample) begin
                r_shift <= {rx, r_shift[7:1]};
            end else begin
                r_shift <= r_shift;
            end
            if (r_state == S_PARITY && w_sample) begin
                r_par_rx <= rx;
            end else begin
                r_par_rx <= r_par_rx;
            end
            if (r_state == S_STOP && w_sample) begin
                r_stop <= rx;
            end else begin
                r_stop <= r_stop;
            end
            if (w_load) begin
                r_parity <= r_par_rx;
                r_msg    <= w_frame_ok ? r_shift : ERR_CHAR;
            end else begin
                r_parity <= r_parity;
                r_msg    <= r_msg;
            end
            if (w_load && w_frame_err) begin
                r_wait_high <= 1'b1;
            end else if (rx) begin
                r_wait_high <= 1'b0;
            end else begin
                r_wait_high <= r_wait_high;
            end
        end
    end

    assign rx_msg      = r_msg;
    assign rx_parity   = r_parity;
    assign rx_complete = r_complete;

endmodule

// File: tb/tb_uart_rx_8e1.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_8e1 : scoreboard bench for uart_rx_8e1. Each fully driven frame
// pushes its expected byte, parity and completion cycle; the monitor pops and
// compares on every rx_complete pulse.
// ---------------------------------------------------------------------------
module tb_uart_rx_8e1;

    logic       clk_3125;
    logic       rst_n;
    logic       rx;
    logic [7:0] rx_msg;
    logic       rx_parity;
    logic       rx_complete;

    typedef struct {
        logic [7:0] msg;
        logic       par;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc      = 0;
    logic       prev_c   = 1'b0;
    logic [7:0] hold_msg = 8'h00;
    logic       hold_par = 1'b0;

    uart_rx_8e1 dut (
        .clk_3125   (clk_3125),
        .rst_n      (rst_n),
        .rx         (rx),
        .rx_msg     (rx_msg),
        .rx_parity  (rx_parity),
        .rx_complete(rx_complete)
    );

    initial clk_3125 = 1'b0;
    always #160 clk_3125 = ~clk_3125;

    // Posedge counter used to time-stamp expected completions.
    always @(posedge clk_3125) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the oldest expectation.
    always @(negedge clk_3125) begin
        exp_t e;
        if (rst_n && rx_complete) begin
            check_val("pulse_width", {31'd0, prev_c}, 32'd0);
            if (sb.size() == 0) begin
                check_val("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_val("msg", {24'd0, rx_msg}, {24'd0, e.msg});
                check_val("parity", {31'd0, rx_parity}, {31'd0, e.par});
                check_val("pulse_time", cyc, e.cyc);
                hold_msg = e.msg;
                hold_par = e.par;
            end
        end
        prev_c <= rx_complete;
    end

    // Drives one frame starting #1 after a posedge. abort_at >= 0 stops driving
    // before that frame edge and pushes no expectation.
    task automatic send_frame(input logic [7:0] d, input logic p, input int abort_at);
        logic [10:0] bits;
        exp_t        e;
        int          start;
        bits  = {1'b1, p, d, 1'b0};
        start = cyc;
        for (int c = 0; c < 154; c++) begin
            if (c == abort_at) return;
            rx = bits[c / 14];
            @(posedge clk_3125);
            #1;
        end
        e.msg = (p == ^d) ? d : 8'h3F;
        e.par = p;
        e.cyc = start + 155;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk_3125);
        #1;
    endtask

    initial begin
        logic [7:0] d;
        int         wait_cnt;
        rst_n = 1'b0;
        rx    = 1'b1;

        // Reset held with rx toggling: outputs stay at reset values.
        for (int i = 0; i < 12; i++) begin
            rx = i[0];
            @(negedge clk_3125);
            check_val("rst_msg", {24'd0, rx_msg}, 32'd0);
            check_val("rst_par", {31'd0, rx_parity}, 32'd0);
            check_val("rst_cmp", {31'd0, rx_complete}, 32'd0);
        end
        rx = 1'b1;
        @(posedge clk_3125);
        #1;
        rst_n = 1'b1;
        idle(5);

        // Single 'A' frame, then 'C' with wrong parity.
        send_frame(8'h41, 1'b0, -1);
        idle(20);
        send_frame(8'h43, 1'b0, -1);
        idle(20);

        // Ten back-to-back frames with correct parity and no idle gap.
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom_range(0, 255));
            if (i == 0) d = 8'h00;
            if (i == 1) d = 8'hFF;
            send_frame(d, ^d, -1);
        end
        idle(30);

        // Start-bit glitch: no completion, outputs unchanged.
        rx = 1'b0;
        repeat (5) @(posedge clk_3125);
        #1;
        idle(200);
        check_val("glitch_sb", sb.size(), 32'd0);
        check_val("glitch_msg", {24'd0, rx_msg}, {24'd0, hold_msg});
        check_val("glitch_par", {31'd0, rx_parity}, {31'd0, hold_par});

        // Reset at frame edge 80, then a clean 8'h5A frame.
        send_frame(8'hA7, 1'b0, 80);
        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk_3125);
        check_val("midrst_msg", {24'd0, rx_msg}, 32'd0);
        check_val("midrst_par", {31'd0, rx_parity}, 32'd0);
        @(posedge clk_3125);
        #1;
        rst_n = 1'b1;
        idle(10);
        send_frame(8'h5A, 1'b0, -1);

        // Drain scoreboard with a bounded wait.
        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 400) begin
            @(posedge clk_3125);
            wait_cnt++;
        end
        idle(5);
        check_val("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
